port_frame_fifo: RTL

- Per-egress-port frame store; one instance sits on each of the three 32-bit lanes produced by the byte-to-word packer.
- Captures packed words with start/end/extra-byte sideband into a circular buffer.
- Discards the frame in progress on delete, error or overflow, so only complete frames are committed.
- Presents committed frames word-by-word to the port transmitter with a valid/ready handshake.

---
 rtl/port_frame_fifo.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/port_frame_fifo.sv
// Per-egress-port frame store: commits only complete frames and
// streams them to the port transmitter over valid/ready.
module port_frame_fifo #(
    parameter int pWORD_WIDTH = 32,
    parameter int pADDR_WIDTH = 9,
    parameter int pCNT_WIDTH  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [pWORD_WIDTH-1:0] i_wr_data,
    input  logic                   i_wr_valid,
    input  logic                   i_wr_delete,
    input  logic [1:0]             i_wr_extra,
    input  logic [1:0]             i_wr_info,
    output logic [pWORD_WIDTH-1:0] o_rd_data,
    output logic                   o_rd_valid,
    input  logic                   i_rd_ready,
    output logic                   o_rd_sof,
    output logic                   o_rd_eof,
    output logic [1:0]             o_rd_extra,
    output logic [pCNT_WIDTH-1:0]  o_frame_cnt,
    output logic                   o_drop,
    output logic                   o_full
);
    localparam int DEPTH = 1 << pADDR_WIDTH;
    localparam int EW    = pWORD_WIDTH + 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [1:0] INFO_SOF = 2'b01;
    localparam logic [1:0] INFO_EOF = 2'b10;

    typedef logic [pADDR_WIDTH:0] ptr_t;

    logic [EW-1:0] mem [DEPTH];
    ptr_t          wr_ptr;
    ptr_t          commit_ptr;
    ptr_t          rd_ptr;
    ptr_t          frame_start;
    ptr_t          used;
    logic [1:0]    state;
    logic [1:0]    phase;
    logic [1:0]    info_q;
    logic          valid_q;
    logic          ovf;
    logic          rise;
    logic          end_edge;
    logic          start_ev;
    logic          abort_ev;
    logic          end_ev;
    logic          mid_ev;
    logic          wr_en;
    logic          commit_ev;
    logic          drop_ev;
    logic          avail;
    logic          load;
    logic          xfer;
    logic          cnt_inc;
    logic          cnt_dec;
    logic [EW-1:0] wr_entry;

    assign used     = wr_ptr - rd_ptr;
    assign o_full   = (used == ptr_t'(DEPTH - 1));
    assign rise     = i_wr_valid && !valid_q;
    assign end_edge = (i_wr_info == INFO_EOF) && (info_q != INFO_EOF);

    assign start_ev = (state == ST_IDLE) && rise
                   && (i_wr_info == INFO_SOF) && !i_wr_delete;
    assign abort_ev = (state == ST_RECV) && (i_wr_delete || !i_wr_valid);
    assign end_ev   = (state == ST_RECV) && !abort_ev && end_edge;
    assign mid_ev   = (state == ST_RECV) && !abort_ev && !end_edge
                   && i_wr_valid && (phase == 2'd0);

    // Once a frame overflows, nothing more of it is stored.
    assign wr_en     = (start_ev || end_ev || mid_ev) && !o_full && !ovf;
    assign commit_ev = end_ev && wr_en;
    assign drop_ev   = abort_ev || (end_ev && !wr_en);
    assign wr_entry  = {end_ev ? i_wr_extra : 2'b00, end_ev, start_ev, i_wr_data};

    assign avail   = (rd_ptr != commit_ptr);
    assign xfer    = o_rd_valid && i_rd_ready;
    assign load    = avail && (!o_rd_valid || i_rd_ready);
    assign cnt_inc = commit_ev;
    assign cnt_dec = xfer && o_rd_eof;

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr[pADDR_WIDTH-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            phase       <= 2'd0;
            info_q      <= 2'b00;
            valid_q     <= 1'b0;
            ovf         <= 1'b0;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            frame_start <= '0;
            o_drop      <= 1'b0;
        end else begin
            valid_q <= i_wr_valid;
            info_q  <= i_wr_info;
            o_drop  <= drop_ev;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        if (start_ev) begin
                            frame_start <= wr_ptr;
                            phase       <= 2'd1;
                            ovf         <= !wr_en;
                            state       <= ST_RECV;
                        end else begin
                            state <= ST_DROP;
                        end
                    end
                end
                ST_RECV: begin
                    phase <= phase + 2'd1;
                    if (drop_ev) begin
                        wr_ptr <= frame_start;
                        ovf    <= 1'b0;
                        state  <= ST_DROP;
                    end else if (commit_ev) begin
                        commit_ptr <= wr_ptr + 1'b1;
                        state      <= ST_DROP;
                    end else if (mid_ev && !wr_en) begin
                        ovf <= 1'b1;
                    end
                end
                default: begin
                    if (!i_wr_valid && !i_wr_delete) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Output register doubles as the synchronous memory read port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr     <= '0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
            o_rd_sof   <= 1'b0;
            o_rd_eof   <= 1'b0;
            o_rd_extra <= 2'b00;
        end else if (load) begin
            {o_rd_extra, o_rd_eof, o_rd_sof, o_rd_data}
                       <= mem[rd_ptr[pADDR_WIDTH-1:0]];
            rd_ptr     <= rd_ptr + 1'b1;
            o_rd_valid <= 1'b1;
        end else if (xfer) begin
            o_rd_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_cnt <= '0;
        end else if (cnt_inc && !cnt_dec) begin
            if (o_frame_cnt != '1) begin
                o_frame_cnt <= o_frame_cnt + 1'b1;
            end
        end else if (cnt_dec && !cnt_inc) begin
            if (o_frame_cnt != '0) begin
                o_frame_cnt <= o_frame_cnt - 1'b1;
            end
        end
    end

endmodule
